// File: rtl/hazard_control_unit_if.sv
// hazard_control_unit_if: pipeline hazard signals between datapath (master) and hazard controller (slave)
interface hazard_control_unit_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W = 16
);
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic [REG_ADDR_W-1:0] ex_rt;
    logic id_uses_rt;
    logic id_muldiv;
    logic id_hilo_read;
    logic ex_mem_read;
    logic ex_branch_taken;
    logic pc_write;
    logic ifid_write;
    logic idex_bubble;
    logic ifid_flush;
    logic muldiv_busy;
    logic [CNT_W-1:0] stall_cnt;
    modport master (
        output id_rs, id_rt, ex_rt, id_uses_rt, id_muldiv, id_hilo_read, ex_mem_read, ex_branch_taken,
        input pc_write, ifid_write, idex_bubble, ifid_flush, muldiv_busy, stall_cnt
    );
    modport slave (
        input id_rs, id_rt, ex_rt, id_uses_rt, id_muldiv, id_hilo_read, ex_mem_read, ex_branch_taken,
        output pc_write, ifid_write, idex_bubble, ifid_flush, muldiv_busy, stall_cnt
    );
endinterface

// File: rtl/hazard_control_unit.sv
// hazard_control_unit: load-use, MULT/DIV structural and branch hazard stall/flush control
module hazard_control_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int MULDIV_LAT = 4,
    parameter int CNT_W = 16
) (
    input logic clk,
    input logic reset,
    hazard_control_unit_if.slave bus
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t state, state_next;
    logic [3:0] cnt, cnt_next;
    logic load_use, struct_haz, stall, flush, issue;
    // hazard detection; reset masks stall and flush so the pipeline free-runs while held
    always_comb begin
        load_use = bus.ex_mem_read && bus.ex_rt != {REG_ADDR_W{1'b0}} &&
                   (bus.ex_rt == bus.id_rs || (bus.id_uses_rt && bus.ex_rt == bus.id_rt));
        struct_haz = state == BUSY && (bus.id_muldiv || bus.id_hilo_read);
        flush = bus.ex_branch_taken && !reset;
        stall = (load_use || struct_haz) && !bus.ex_branch_taken && !reset;
        issue = bus.id_muldiv && !stall && !bus.ex_branch_taken && !reset;
    end
    // pipeline control outputs; a taken branch overrides any stall source
    always_comb begin
        bus.pc_write = !stall;
        bus.ifid_write = !stall;
        bus.idex_bubble = stall || flush;
        bus.ifid_flush = flush;
        bus.muldiv_busy = state == BUSY;
    end
    // MULT/DIV occupancy: busy for MULDIV_LAT cycles after the issue cycle
    always_comb begin
        state_next = state;
        cnt_next = cnt;
        if (state == IDLE) begin
            state_next = issue ? BUSY : IDLE;
            cnt_next = issue ? 4'(MULDIV_LAT - 1) : cnt;
        end else begin
            state_next = cnt != 4'd0 ? BUSY : IDLE;
            cnt_next = cnt != 4'd0 ? cnt - 4'd1 : cnt;
        end
    end
    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt <= 4'd0;
        end else begin
            state <= state_next;
            cnt <= cnt_next;
        end
    end
    // saturating count of cycles with the PC held
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            bus.stall_cnt <= '0;
        else if (stall && bus.stall_cnt != {CNT_W{1'b1}})
            bus.stall_cnt <= bus.stall_cnt + CNT_W'(1);
    end
endmodule

// File: tb/tb_hazard_control_unit.sv
// tb_hazard_control_unit: randomized and directed checks against a cycle-count reference model
module tb_hazard_control_unit;
    localparam int LAT = 4;
    localparam int MAXC = 65535;
    logic clk = 1'b0;
    logic reset;
    int checks = 0;
    int failures = 0;
    int rem;
    int scnt;
    hazard_control_unit_if bus ();
    hazard_control_unit #(.MULDIV_LAT(LAT)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input bit urt, input bit md,
                         input bit hl, input bit mr, input logic [4:0] ert, input bit br);
        bus.id_rs = rs;
        bus.id_rt = rt;
        bus.id_uses_rt = urt;
        bus.id_muldiv = md;
        bus.id_hilo_read = hl;
        bus.ex_mem_read = mr;
        bus.ex_rt = ert;
        bus.ex_branch_taken = br;
    endtask
    function automatic bit exp_stall();
        bit lu, sh;
        lu = bus.ex_mem_read && bus.ex_rt != 0 &&
             (bus.ex_rt == bus.id_rs || (bus.id_uses_rt && bus.ex_rt == bus.id_rt));
        sh = rem > 0 && (bus.id_muldiv || bus.id_hilo_read);
        return (lu || sh) && !bus.ex_branch_taken;
    endfunction
    task automatic cycle(input bit do_chk);
        bit st, br;
        #2;
        st = exp_stall();
        br = bus.ex_branch_taken;
        if (do_chk) begin
            check("pc_write", 32'(bus.pc_write), 32'(!st));
            check("ifid_write", 32'(bus.ifid_write), 32'(!st));
            check("idex_bubble", 32'(bus.idex_bubble), 32'(st || br));
            check("ifid_flush", 32'(bus.ifid_flush), 32'(br));
            check("muldiv_busy", 32'(bus.muldiv_busy), 32'(rem > 0));
            check("stall_cnt", 32'(bus.stall_cnt), scnt);
        end
        @(posedge clk);
        if (bus.id_muldiv && !st && !br) rem = LAT;
        else if (rem > 0) rem--;
        if (st && scnt < MAXC) scnt++;
        #1;
    endtask
    initial begin
        rem = 0;
        scnt = 0;
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #12;
        drive(8, 0, 0, 1, 0, 1, 8, 0);
        #1;
        check("rst_pc_write", 32'(bus.pc_write), 1);
        check("rst_ifid_write", 32'(bus.ifid_write), 1);
        check("rst_bubble", 32'(bus.idex_bubble), 0);
        check("rst_flush", 32'(bus.ifid_flush), 0);
        check("rst_busy", 32'(bus.muldiv_busy), 0);
        check("rst_cnt", 32'(bus.stall_cnt), 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        drive(8, 0, 0, 0, 0, 1, 8, 0);
        cycle(1);
        check("lu_cnt", 32'(bus.stall_cnt), 1);
        drive(8, 0, 0, 0, 0, 0, 8, 0);
        cycle(1);
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        cycle(1);
        drive(1, 9, 0, 0, 0, 1, 9, 0);
        cycle(1);
        drive(1, 9, 1, 0, 0, 1, 9, 0);
        cycle(1);
        check("rt_cnt", 32'(bus.stall_cnt), 2);
        drive(0, 0, 0, 1, 0, 0, 0, 0);
        cycle(1);
        drive(0, 0, 0, 0, 1, 0, 0, 0);
        repeat (5) cycle(1);
        check("mul_cnt", 32'(bus.stall_cnt), 6);
        drive(8, 0, 0, 0, 0, 1, 8, 1);
        cycle(1);
        drive(0, 0, 0, 1, 0, 0, 0, 1);
        cycle(1);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        cycle(1);
        check("br_cnt", 32'(bus.stall_cnt), 6);
        repeat (3000) begin
            drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 25, 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), $urandom_range(0, 99) < 15);
            cycle(1);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (LAT + 1) cycle(1);
        drive(0, 0, 0, 1, 0, 0, 0, 0);
        cycle(1);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        cycle(1);
        cycle(1);
        drive(8, 0, 0, 0, 0, 1, 8, 0);
        reset = 1'b1;
        #1;
        check("arst_busy", 32'(bus.muldiv_busy), 0);
        check("arst_cnt", 32'(bus.stall_cnt), 0);
        check("arst_pc_write", 32'(bus.pc_write), 1);
        check("arst_bubble", 32'(bus.idex_bubble), 0);
        rem = 0;
        scnt = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        drive(0, 0, 0, 1, 0, 0, 0, 0);
        cycle(1);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (LAT + 1) cycle(1);
        drive(8, 0, 0, 0, 0, 1, 8, 0);
        repeat (MAXC + 3) cycle(0);
        cycle(1);
        cycle(1);
        check("sat_cnt", 32'(bus.stall_cnt), 32'hFFFF);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
Pipeline hazard and stall controller for the 5-stage MIPS datapath. It watches the ID and EX stages and detects load-use data hazards, structural hazards on the multi-cycle MULT/DIV unit, and taken-branch control hazards. From these it drives the PC / IF-ID write enables, the ID-EX bubble insert and the IF-ID flush. It also keeps a saturating stall-cycle performance counter.

Parameters:
REG_ADDR_W, 5, register-specifier width
MULDIV_LAT, 4, cycles the MULT/DIV unit stays busy after issue (legal range 1..15)
CNT_W, 16, width of the stall performance counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
id_rs  in  REG_ADDR_W  rs of the instruction in ID
id_rt  in  REG_ADDR_W  rt of the instruction in ID
id_uses_rt  in  1  ID instruction reads rt as a source
id_muldiv  in  1  ID instruction is MULT/MULTU/DIV/DIVU
id_hilo_read  in  1  ID instruction is MFHI/MFLO
ex_mem_read  in  1  EX instruction is a load
ex_rt  in  REG_ADDR_W  destination register of the EX load
ex_branch_taken  in  1  branch resolved taken in EX this cycle
pc_write  out  1  PC register enable
ifid_write  out  1  IF-ID register enable
idex_bubble  out  1  replace the ID-EX input with a NOP
ifid_flush  out  1  clear IF-ID to a NOP
muldiv_busy  out  1  MULT/DIV unit occupied
stall_cnt  out  CNT_W  count of stalled cycles, saturating

Behaviour:
- Reset, asynchronous: state=IDLE, busy counter=0, stall_cnt=0. While reset is high, outputs are forced to pc_write=1, ifid_write=1, idex_bubble=0, ifid_flush=0, muldiv_busy=0.
- load_use = ex_mem_read && ex_rt!=0 && (ex_rt==id_rs || (id_uses_rt && ex_rt==id_rt)). This is combinational, same cycle.
- struct_haz = (state==BUSY) && (id_muldiv || id_hilo_read). This is combinational.
- stall = (load_use || struct_haz) && !ex_branch_taken.
- Stall outputs: pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0.
- Flush (ex_branch_taken=1): ifid_flush=1, idex_bubble=1, pc_write=1, ifid_write=1.
  - Flush has priority over every stall source, because the squashed ID instruction cannot stall.
- Otherwise: pc_write=1, ifid_write=1, idex_bubble=0, ifid_flush=0.
- MULT/DIV FSM, registered:
  - IDLE to BUSY on issue, where issue = id_muldiv && !stall && !ex_branch_taken. On issue, load cnt=MULDIV_LAT-1.
  - BUSY with cnt!=0: decrement cnt.
  - BUSY with cnt==0: go to IDLE next edge.
  - muldiv_busy = (state==BUSY). It is high for exactly MULDIV_LAT cycles, starting the cycle after the issue cycle.
  - A MULT/DIV in ID while BUSY stalls until the cycle after busy drops. It then issues normally.
  - No back-to-back overlap is allowed.
  - A branch flush does not cancel an already-issued MULT/DIV; BUSY runs to completion.
- stall_cnt increments on each rising edge where pc_write==0 was sampled in that cycle. It holds at all-ones (no wrap).
- Simultaneous load_use and struct_haz: a single stall per cycle, counted once.
- Register $0 never causes a load-use stall.
- Load-use stall is exactly one cycle. The next cycle the load is in MEM, ex_mem_read drops, and forwarding covers the dependency.
- Reset asserted mid-BUSY returns immediately to IDLE; muldiv_busy drops with no clock edge needed.

Test Plan:
- Load-use: ex_mem_read=1, ex_rt=8, id_rs=8 -> pc_write=0, ifid_write=0, idex_bubble=1 for exactly 1 cycle; stall_cnt 0->1.
- $0 and rt gating: ex_rt=0, id_rs=0 -> no stall. Separately, ex_rt=9, id_rt=9, id_uses_rt=0 -> no stall; then id_uses_rt=1 -> stall.
- MULT/DIV structural (MULDIV_LAT=4): issue MULT at cycle T -> muldiv_busy high for T+1..T+4. An MFLO in ID at T+1 stalls 4 cycles, releases at T+5, and stall_cnt=4.
- Branch priority: load_use condition true and ex_branch_taken=1 -> ifid_flush=1, idex_bubble=1, pc_write=1; stall_cnt unchanged. With id_muldiv=1 instead -> no issue, state stays IDLE.
- Saturation: preset by holding load_use for 65535+3 cycles -> stall_cnt sticks at 0xFFFF.
- Async reset: assert reset asynchronously at T+2 of BUSY, between edges -> muldiv_busy=0 and stall_cnt=0 at once; after release, next MULT issues normally.
